// File: rtl/flappy_game_controller_if.sv
// Bundle between the game controller and its neighbours: the tap edge
// detector, the box register and the VGA renderer / HEX display driver.
interface flappy_game_controller_if;

   logic       tap;          // one-tick pulse from the input edge detector
   logic [6:0] box_y;        // current box top row from the box register
   logic       box_tap;      // tap forwarded to the box register
   logic       box_restart;  // hold the box at its start position
   logic       box_enable;   // let the box move
   logic [7:0] pipe_x;       // left column of the pipe
   logic [6:0] gap_top;      // first open row of the pipe gap
   logic [3:0] score_tens;   // BCD tens digit
   logic [3:0] score_ones;   // BCD ones digit
   logic [1:0] game_state;   // IDLE=0, PLAYING=1, DYING=2, GAME_OVER=3
   logic       game_over;    // high while game_state is GAME_OVER

   // Environment side: drives the player input and box position.
   modport master (
      output tap, box_y,
      input  box_tap, box_restart, box_enable, pipe_x, gap_top,
             score_tens, score_ones, game_state, game_over
   );

   // Controller side.
   modport slave (
      input  tap, box_y,
      output box_tap, box_restart, box_enable, pipe_x, gap_top,
             score_tens, score_ones, game_state, game_over
   );

endinterface

// File: rtl/flappy_game_controller.sv
// Flappy-box game sequencer: game-state machine, pipe scrolling with an
// LFSR-chosen gap, box/pipe/floor/ceiling collision and a saturating
// two-digit BCD score. Everything advances on game_tick_clock.
module flappy_game_controller #(
   parameter int SCREEN_W    = 160,
   parameter int BOX_X       = 20,
   parameter int BOX_SIZE    = 4,
   parameter int PIPE_W      = 10,
   parameter int GAP_H       = 30,
   parameter int GAP_MIN     = 8,
   parameter int FLOOR_Y     = 116,
   parameter int DEATH_TICKS = 30
) (
   input  logic                     game_tick_clock,
   input  logic                     reset,
   flappy_game_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PLAYING   = 2'd1,
      ST_DYING     = 2'd2,
      ST_GAME_OVER = 2'd3
   } state_t;

   localparam int           CNT_W      = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_TICKS - 1);
   localparam logic [7:0]   PIPE_START = 8'(SCREEN_W - 1);
   // Pipe column at which its right edge is about to clear the box's left edge.
   localparam logic [7:0]   SCORE_X    = 8'(BOX_X - PIPE_W + 1);
   localparam logic [6:0]   GAP_RESET  = 7'd40;
   localparam logic [7:0]   LFSR_SEED  = 8'hA5;

   // Collision geometry constants in the 9-bit comparison domain.
   localparam logic [8:0]   BOX_L9     = 9'(BOX_X);
   localparam logic [8:0]   BOX_R9     = 9'(BOX_X + BOX_SIZE - 1);
   localparam logic [8:0]   FLOOR9     = 9'(FLOOR_Y);

   state_t           state;
   logic [7:0]       pipe_x_q;
   logic [6:0]       gap_top_q;
   logic [3:0]       tens_q;
   logic [3:0]       ones_q;
   logic [CNT_W-1:0] death_cnt;
   logic [7:0]       lfsr;
   logic             box_restart_q;
   logic             box_enable_q;
   logic             game_over_q;

   // ------------------------------------------------------------------
   // Collision detection (only meaningful while PLAYING)
   // ------------------------------------------------------------------
   // Widened to 9 bits so that box/pipe/gap bottoms and rights never wrap.
   logic [8:0] box_top9, box_bot9;
   logic [8:0] pipe_l9, pipe_r9;
   logic [8:0] gap_t9, gap_b9;
   logic       hit_ceiling, hit_floor, x_overlap, outside_gap, collision;

   assign box_top9    = {2'b00, bus.box_y};
   assign box_bot9    = box_top9 + 9'(BOX_SIZE - 1);
   assign pipe_l9     = {1'b0, pipe_x_q};
   assign pipe_r9     = pipe_l9 + 9'(PIPE_W - 1);
   assign gap_t9      = {2'b00, gap_top_q};
   assign gap_b9      = gap_t9 + 9'(GAP_H - 1);

   assign hit_ceiling = (box_top9 == 9'd0);
   assign hit_floor   = (box_bot9 >= FLOOR9);
   assign x_overlap   = (pipe_l9 <= BOX_R9) && (pipe_r9 >= BOX_L9);
   assign outside_gap = (box_top9 < gap_t9) || (box_bot9 > gap_b9);
   assign collision   = (state == ST_PLAYING) &&
                        (hit_ceiling || hit_floor || (x_overlap && outside_gap));

   // ------------------------------------------------------------------
   // Score increment and next gap
   // ------------------------------------------------------------------
   function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
      logic [7:0] res;
      if (tens == 4'd9 && ones == 4'd9)
         res = {tens, ones};               // saturate at 99
      else if (ones == 4'd9)
         res = {tens + 4'd1, 4'd0};        // carry into tens
      else
         res = {tens, ones + 4'd1};
      return res;
   endfunction

   logic [7:0] score_next;
   logic [6:0] gap_next;
   logic       pipe_wrap;

   assign score_next = bcd_inc(tens_q, ones_q);
   assign gap_next   = 7'(GAP_MIN) + {1'b0, lfsr[5:0]};
   // Wrap at column 0, and also recover if the pipe ever sits off-screen.
   assign pipe_wrap  = (pipe_x_q == 8'd0) || (pipe_x_q > PIPE_START);

   // ------------------------------------------------------------------
   // Gap LFSR: free-running in every state, seeded nonzero so it never locks up
   // ------------------------------------------------------------------
   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge game_tick_clock) begin
      if (reset)
         lfsr <= LFSR_SEED;
      else
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // ------------------------------------------------------------------
   // Game FSM with pipe, score, death counter and registered state flags
   // ------------------------------------------------------------------
   always_ff @(posedge game_tick_clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         pipe_x_q      <= PIPE_START;
         gap_top_q     <= GAP_RESET;
         tens_q        <= 4'd0;
         ones_q        <= 4'd0;
         death_cnt     <= '0;
         box_restart_q <= 1'b1;
         box_enable_q  <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.tap) begin
                  state         <= ST_PLAYING;
                  box_restart_q <= 1'b0;
                  box_enable_q  <= 1'b1;
               end
            end

            ST_PLAYING: begin
               if (collision) begin
                  // Collision beats both scoring and wrapping on the same tick.
                  state        <= ST_DYING;
                  death_cnt    <= '0;
                  box_enable_q <= 1'b0;
               end else begin
                  if (pipe_wrap) begin
                     pipe_x_q  <= PIPE_START;
                     gap_top_q <= gap_next;
                  end else begin
                     pipe_x_q  <= pipe_x_q - 8'd1;
                  end
                  if (pipe_x_q == SCORE_X)
                     {tens_q, ones_q} <= score_next;
               end
            end

            ST_DYING: begin
               if (death_cnt == CNT_LAST) begin
                  state       <= ST_GAME_OVER;
                  death_cnt   <= '0;
                  game_over_q <= 1'b1;
               end else begin
                  death_cnt   <= death_cnt + 1'b1;
               end
            end

            ST_GAME_OVER: begin
               if (bus.tap) begin
                  // New round: fresh pipe and score, gap stays where it was.
                  state         <= ST_IDLE;
                  pipe_x_q      <= PIPE_START;
                  tens_q        <= 4'd0;
                  ones_q        <= 4'd0;
                  death_cnt     <= '0;
                  box_restart_q <= 1'b1;
                  game_over_q   <= 1'b0;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The start tap doubles as the first flap, so IDLE forwards taps too.
   assign bus.box_tap     = bus.tap && ((state == ST_IDLE) || (state == ST_PLAYING));
   assign bus.box_restart = box_restart_q;
   assign bus.box_enable  = box_enable_q;
   assign bus.pipe_x      = pipe_x_q;
   assign bus.gap_top     = gap_top_q;
   assign bus.score_tens  = tens_q;
   assign bus.score_ones  = ones_q;
   assign bus.game_state  = state;
   assign bus.game_over   = game_over_q;

   // ------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------
   lfsr_nonzero: assert property (@(posedge game_tick_clock) disable iff (reset)
      lfsr != 8'h00);

   flags_match_state: assert property (@(posedge game_tick_clock) disable iff (reset)
      (box_restart_q == (state == ST_IDLE)) &&
      (box_enable_q  == (state == ST_PLAYING)) &&
      (game_over_q   == (state == ST_GAME_OVER)));

   score_is_bcd: assert property (@(posedge game_tick_clock) disable iff (reset)
      (tens_q <= 4'd9) && (ones_q <= 4'd9));

endmodule

// File: doc/flappy_game_controller.md
# flappy_game_controller

Top-level game sequencer for the flappy-box game. It runs the game-state machine (idle, playing, dying, game over) and gates player taps into the box register. It also scrolls a single pipe obstacle with a pseudo-random gap and detects collisions between the box and the pipe, floor or ceiling. It keeps a two-digit BCD score for the HEX displays and sits between the input edge detector, the box register and the VGA renderer.

## Interface
Parameters:
- SCREEN_W, 160: horizontal playfield width in pixels.
- BOX_X, 20: fixed left x of the box.
- BOX_SIZE, 4: box edge length in pixels.
- PIPE_W, 10: pipe width in pixels.
- GAP_H, 30: vertical gap height in pixels.
- GAP_MIN, 8: minimum gap_top.
- FLOOR_Y, 116: first floor row. The box is dead if its bottom row is at or beyond this row.
- DEATH_TICKS, 30: ticks spent in DYING.

Ports:
- game_tick_clock, in, 1: the one clock. All state updates on its posedge.
- reset, in, 1: synchronous, active-high.
- tap, in, 1: one-tick pulse from the input edge detector.
- box_y, in, 7: current box top y from the box register.
- box_tap, out, 1: tap forwarded to the box register.
- box_restart, out, 1: holds the box at its start position.
- box_enable, out, 1: lets the box move.
- pipe_x, out, 8: left x of the pipe.
- gap_top, out, 7: first open row of the gap.
- score_tens, out, 4: BCD tens digit of the score.
- score_ones, out, 4: BCD ones digit of the score.
- game_state, out, 2: IDLE=0, PLAYING=1, DYING=2, GAME_OVER=3.
- game_over, out, 1: high when game_state is GAME_OVER.

## Operation
- Reset values: game_state=IDLE, pipe_x=SCREEN_W-1, gap_top=40, score=00, death counter=0, LFSR=8'hA5.
  - Consequently box_restart=1, box_enable=0 and game_over=0 out of reset.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4. Shifts on every tick in every state.
  - Any sequence derived from it must never reach all-zero.
- State transitions:
  - IDLE: tap moves to PLAYING. pipe_x, gap_top and score are held.
  - PLAYING, when a collision is present: move to DYING. pipe_x and score are frozen on that edge.
  - PLAYING, no collision: pipe_x decrements by 1 per tick.
    - When pipe_x==0 it wraps to SCREEN_W-1 on the next tick and gap_top loads GAP_MIN + LFSR[5:0].
    - With the defaults gap_top lies in 8..71.
  - PLAYING, scoring: on the edge where pipe_x goes from BOX_X-PIPE_W+1 to BOX_X-PIPE_W, the score increments in BCD.
    - Ones digit wraps 9→0 with a carry into tens.
    - The score saturates at 99.
  - DYING: the death counter counts 0..DEATH_TICKS-1, then the state moves to GAME_OVER. Taps are ignored.
  - GAME_OVER: tap moves to IDLE, reloading pipe_x=SCREEN_W-1, score=00 and the counter. gap_top is kept.
- Collision is combinational from the current registers and box_y, and is evaluated only in PLAYING. It is true when any of these holds:
  - box_y==0 (ceiling).
  - box_y+BOX_SIZE-1 ≥ FLOOR_Y (floor).
  - Pipe hit: the x ranges overlap (pipe_x ≤ BOX_X+BOX_SIZE-1 and pipe_x+PIPE_W-1 ≥ BOX_X), and the box pokes outside the gap (box_y < gap_top, or box_y+BOX_SIZE-1 > gap_top+GAP_H-1).
- Arithmetic widths:
  - Collision arithmetic uses 9-bit unsigned intermediates, so no sum can wrap.
  - pipe_x is compared against SCREEN_W-1 before wrapping.
- Outputs per state:
  - box_tap = tap when state is IDLE or PLAYING, else 0. The start tap is also the first flap.
  - box_restart = (state==IDLE).
  - box_enable = (state==PLAYING).

## Timing
- All outputs except box_tap are registered or decoded from registered state. box_tap is combinational from tap with zero latency.
- Tap in IDLE at edge n gives game_state=PLAYING after edge n. pipe_x first decrements at edge n+1.
- Collision present before edge n: DYING after edge n. GAME_OVER after edge n+DEATH_TICKS.
- Simultaneous events:
  - Collision and a score edge on the same tick: collision wins and the score is not incremented.
  - Collision and a pipe wrap on the same tick: collision wins and there is no wrap.
  - Tap and collision on the same tick: box_tap is still forwarded; the state still goes to DYING.
- Reset asserted in any state returns every register to its reset value on that edge. reset has priority over tap.

## Test plan
- **Reset values:** reset for 2 ticks → game_state=0, pipe_x=159, gap_top=40, score=00, box_restart=1, box_tap follows tap.
- **Scoring pass:** tap, then box_y=50 held (gap 40..69) → after 148 PLAYING edges pipe_x=11 and score=00; the 149th edge gives pipe_x=10 and score=01; pipe_x wraps 0→159 with gap_top = 8 + LFSR[5:0].
- **Pipe collision:** tap, box_y=20 held → pipe_x=23 after 136 edges; the next edge gives DYING with pipe_x frozen at 23; 30 edges later game_over=1; taps in DYING produce box_tap=0.
- **Floor and ceiling:** tap, box_y=113 → DYING after the first PLAYING edge. Repeat with box_y=0 → same result.
- **BCD and saturation:** force score=09 via repeated passes → next pass gives 10. From 99, a further pass stays at 99.
- **Restart and mid-game reset:** in GAME_OVER, tap → IDLE with score=00 and pipe_x=159. Reset pulsed mid-PLAYING → all reset values on the next edge, LFSR=8'hA5.
